// File: rtl/sad_block_accumulator.sv
// sad_block_accumulator: accumulates the sum of absolute differences (SAD)
// for each candidate block of a raster-scanned search window.
// Each SAD result is presented with its candidate row and column to the
// downstream minimum-SAD register.
// When no result is valid, SADOut is held at all-ones so that the downstream
// minimum compare never selects it.
// Optional feature macro: SAD_EARLY_TERM_EN. When it is defined, the
// BestSADIn port is added. A candidate is suppressed once its running sum
// reaches BestSADIn.
//
// state   | meaning
// S_IDLE  | waiting for Start; all counters at zero
// S_ACCUM | accepting pixel pairs and summing |F-T|
// S_EMIT  | one cycle: result is on the outputs, counters advance
// S_DONE  | one cycle: Done pulse after the last candidate
module sad_block_accumulator #(
  parameter int BLOCK_W     = 4,
  parameter int BLOCK_H     = 4,
  parameter int SEARCH_ROWS = 8,
  parameter int SEARCH_COLS = 8,
  parameter int PIX_W       = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             InValid,
  output logic             InReady,
  input  logic [PIX_W-1:0] FramePixel,
  input  logic [PIX_W-1:0] TemplatePixel,
`ifdef SAD_EARLY_TERM_EN
  input  logic [31:0]      BestSADIn,
`endif
  output logic [31:0]      SADOut,
  output logic [7:0]       SADRowOut,
  output logic [7:0]       SADColumnOut,
  output logic             SADValid,
  output logic             Busy,
  output logic             Done
);

  localparam int NPIX  = BLOCK_W * BLOCK_H;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [7:0] LAST_ROW = 8'(SEARCH_ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(SEARCH_COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT, S_DONE} state_t;

  state_t           state, state_next;
  logic [31:0]      acc;
  logic [CNT_W-1:0] pix_cnt;
  logic [7:0]       row_cnt, col_cnt;
  logic             rejected;

  logic [PIX_W-1:0] abs_diff;
  logic [31:0]      sum_next;
  logic             beat, last_beat, last_cand, early_hit, reject_now;

  // Per-beat arithmetic and decode of the current candidate position.
  always_comb begin
    abs_diff   = (FramePixel >= TemplatePixel) ? (FramePixel - TemplatePixel)
                                               : (TemplatePixel - FramePixel);
    sum_next   = acc + 32'(abs_diff);
    beat       = InValid && (state == S_ACCUM);
    last_beat  = beat && (pix_cnt == LAST_PIX);
    last_cand  = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
`ifdef SAD_EARLY_TERM_EN
    early_hit  = (sum_next >= BestSADIn);
`else
    early_hit  = 1'b0;
`endif
    reject_now = rejected || early_hit;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and the handshake/status outputs decoded from state.
  always_comb begin
    state_next = state;
    InReady    = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE:  if (Start) state_next = S_ACCUM;
      S_ACCUM: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (last_beat) state_next = S_EMIT;
      end
      S_EMIT: begin
        Busy       = 1'b1;
        state_next = last_cand ? S_DONE : S_ACCUM;
      end
      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Accumulator and counters. The result registers are loaded on the last
  // beat, so they are visible during the EMIT cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc          <= '0;
      pix_cnt      <= '0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      rejected     <= 1'b0;
      SADOut       <= 32'hFFFF_FFFF;
      SADRowOut    <= '0;
      SADColumnOut <= '0;
      SADValid     <= 1'b0;
    end else begin
      SADValid <= 1'b0;
      SADOut   <= 32'hFFFF_FFFF;
      case (state)
        S_ACCUM: begin
          if (beat) begin
            acc      <= sum_next;
            rejected <= reject_now;
            if (!last_beat) pix_cnt <= pix_cnt + CNT_W'(1);
            if (last_beat && !reject_now) begin
              SADValid     <= 1'b1;
              SADOut       <= sum_next;
              SADRowOut    <= row_cnt;
              SADColumnOut <= col_cnt;
            end
          end
        end
        S_EMIT: begin
          acc      <= '0;
          pix_cnt  <= '0;
          rejected <= 1'b0;
          if (col_cnt == LAST_COL) begin
            col_cnt <= '0;
            row_cnt <= (row_cnt == LAST_ROW) ? 8'd0 : row_cnt + 8'd1;
          end else begin
            col_cnt <= col_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Testbench for sad_block_accumulator (2x2 blocks, 2x3 search window).
// A behavioural model sums the accepted pixel pairs and derives the
// expected per-cycle outputs.
module tb_sad_block_accumulator;

  localparam int BW    = 2;
  localparam int BH    = 2;
  localparam int RW    = 2;
  localparam int CL    = 3;
  localparam int NPIX  = BW * BH;
  localparam int TOTAL = NPIX * RW * CL;
  localparam int MAXC  = 400;
`ifdef SAD_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        Clk, Rst, Start, InValid, InReady, SADValid, Busy, Done;
  logic [7:0]  FramePixel, TemplatePixel, SADRowOut, SADColumnOut;
  logic [31:0] SADOut, best;

  int n_checks = 0;
  int n_pass   = 0;
  int lr = 0;
  int lc = 0;

  sad_block_accumulator #(
    .BLOCK_W(BW), .BLOCK_H(BH), .SEARCH_ROWS(RW), .SEARCH_COLS(CL), .PIX_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InValid(InValid), .InReady(InReady),
    .FramePixel(FramePixel), .TemplatePixel(TemplatePixel),
`ifdef SAD_EARLY_TERM_EN
    .BestSADIn(best),
`endif
    .SADOut(SADOut), .SADRowOut(SADRowOut), .SADColumnOut(SADColumnOut),
    .SADValid(SADValid), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_quiet();
    chk("quiet_valid", 32'(SADValid), 32'd0);
    chk("quiet_sad",   SADOut, 32'hFFFF_FFFF);
    chk("quiet_ready", 32'(InReady), 32'd0);
    chk("quiet_busy",  32'(Busy), 32'd0);
    chk("quiet_done",  32'(Done), 32'd0);
    chk("quiet_row",   32'(SADRowOut), 32'(lr));
    chk("quiet_col",   32'(SADColumnOut), 32'(lc));
  endtask

  // Pixel pair for the beat with global index b of a scan.
  task automatic gen(input int mode, input int b, output logic [7:0] f, output logic [7:0] t);
    logic [7:0] fv [4];
    logic [7:0] tv [4];
    fv = '{8'd10, 8'd20, 8'd30, 8'd40};
    tv = '{8'd12, 8'd15, 8'd30, 8'd50};
    f = 8'($urandom_range(0, 255));
    t = 8'($urandom_range(0, 255));
    case (mode)
      2: begin f = 8'd255; t = 8'd0;   end
      3: begin f = 8'd0;   t = 8'd255; end
      4: t = f;
      5: if (b < 4) begin f = fv[b]; t = tv[b]; end
      6: begin f = 8'd1;   t = 8'd0;   end
      7: begin
        if (b < 2)      begin f = 8'd6; t = 8'd0; end
        else if (b < 4) t = f;
        else if (b < 8) begin f = 8'd3; t = 8'd4; end
      end
      default: ;
    endcase
  endtask

  // One full scan; abort_after >= 0 asserts Rst once that many beats are in.
  task automatic run_scan(input int mode, input int abort_after);
    int acc = 0, beats = 0, cand, fi, ti;
    logic [31:0] es = '0;
    bit ee = 0, ev = 0, ed = 0, nee, nev, nd, rej = 0, fin = 0, exp_ready;
    logic [7:0] f, t;
    @(negedge Clk);
    Start = 1'b1;
    InValid = 1'b1;
    FramePixel = 8'($urandom_range(0, 255));
    TemplatePixel = 8'($urandom_range(0, 255));
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(negedge Clk);
      exp_ready = (beats < TOTAL) && !ee;
      chk("sad_valid", 32'(SADValid), 32'(ev));
      chk("sad_out",   SADOut, ev ? es : 32'hFFFF_FFFF);
      chk("row_out",   32'(SADRowOut), 32'(lr));
      chk("col_out",   32'(SADColumnOut), 32'(lc));
      chk("in_ready",  32'(InReady), 32'(exp_ready));
      chk("busy",      32'(Busy), 32'(!ed));
      chk("done",      32'(Done), 32'(ed));
      if (ed) begin
        Start = 1'b0;
        InValid = 1'b0;
        fin = 1;
        break;
      end
      nd = ee && (beats == TOTAL);
      nee = 0;
      nev = 0;
      if (abort_after >= 0 && beats == abort_after) begin
        Rst = 1'b1;
        InValid = 1'b1;
        Start = 1'b1;
        fin = 1;
        break;
      end
      Start = 1'($urandom_range(0, 1));
      case (mode)
        0, 5:    InValid = ($urandom_range(0, 3) != 0);
        1:       InValid = ((cyc % 3) == 0);
        default: InValid = 1'b1;
      endcase
      gen(mode, beats, f, t);
      FramePixel = f;
      TemplatePixel = t;
      if (InValid && exp_ready) begin
        fi = int'(f);
        ti = int'(t);
        acc += (fi > ti) ? fi - ti : ti - fi;
        beats++;
        if (ET && 32'(acc) >= best) rej = 1;
        if (beats % NPIX == 0) begin
          cand = beats / NPIX - 1;
          nee = 1;
          nev = !rej;
          if (!rej) begin
            es = 32'(acc);
            lr = cand / CL;
            lc = cand % CL;
          end
          rej = 0;
          acc = 0;
        end
      end
      ee = nee;
      ev = nev;
      ed = nd;
    end
    if (!fin) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    Rst = 1'b1;
    Start = 1'b0;
    InValid = 1'b0;
    FramePixel = '0;
    TemplatePixel = '0;
    best = 32'hFFFF_FFFF;
    @(negedge Clk);
    @(negedge Clk);
    check_quiet();
    Rst = 1'b0;

    run_scan(5, -1);
    @(negedge Clk); check_quiet();
    run_scan(1, -1);
    @(negedge Clk); check_quiet();
    run_scan(2, -1);
    @(negedge Clk); check_quiet();
    run_scan(3, -1);
    @(negedge Clk); check_quiet();
    run_scan(4, -1);
    @(negedge Clk); check_quiet();

    run_scan(0, 2);
    @(negedge Clk);
    Rst = 1'b0;
    Start = 1'b0;
    InValid = 1'b0;
    lr = 0;
    lc = 0;
    check_quiet();
    repeat (3) begin
      @(negedge Clk);
      check_quiet();
    end
    run_scan(6, -1);
    @(negedge Clk); check_quiet();

    for (int i = 0; i < 4; i++) begin
      run_scan(0, -1);
      @(negedge Clk); check_quiet();
    end

    best = ET ? 32'd10 : 32'hFFFF_FFFF;
    run_scan(7, -1);
    @(negedge Clk); check_quiet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sad_block_accumulator.md
# sad_block_accumulator

Upstream stage of the minimum-SAD tracking register in the motion-estimation path. Consumes a stream of frame/template pixel pairs, one candidate block at a time in raster scan order over the search window. Accumulates the sum of absolute differences (SAD) for each candidate and presents it, with the candidate's row and column, to the downstream minimum register. The downstream register compares every cycle, so whenever no result is valid this block holds its SAD output at the all-ones "never-minimum" value.

## Interface
- BLOCK_W, 4: candidate block width in pixels.
- BLOCK_H, 4: candidate block height in pixels.
- SEARCH_ROWS, 8: number of candidate rows; at most 256.
- SEARCH_COLS, 8: number of candidate columns; at most 256.
- PIX_W, 8: pixel width; BLOCK_W*BLOCK_H*(2^PIX_W-1) must be below 2^32-1.
- Clk  in  1  clock; all logic is clocked on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  begins a scan; sampled only in IDLE.
- InValid  in  1  pixel pair valid.
- InReady  out  1  block accepts the pair; a beat transfers when InValid && InReady.
- FramePixel  in  PIX_W  search-frame pixel.
- TemplatePixel  in  PIX_W  template pixel.
- BestSADIn  in  32  current minimum fed back from downstream; present only with SAD_EARLY_TERM_EN.
- SADOut  out  32  candidate SAD; 32'hFFFF_FFFF when SADValid is low.
- SADRowOut  out  8  candidate row.
- SADColumnOut  out  8  candidate column.
- SADValid  out  1  one-cycle pulse per emitted candidate.
- Busy  out  1  high in ACCUM and EMIT.
- Done  out  1  one-cycle pulse after the final candidate.

## Operation
- Reset values: SADOut=32'hFFFF_FFFF, SADRowOut=0, SADColumnOut=0, SADValid=0, InReady=0, Busy=0, Done=0. State returns to IDLE; the accumulator, pixel counter, row counter and column counter clear to 0.
- States:
  - IDLE: Start moves to ACCUM; row, column, accumulator and pixel counter are 0.
  - ACCUM: InReady=1. Each beat adds |FramePixel-TemplatePixel| to the accumulator. The difference is PIX_W bits, zero-extended to 32. The pixel counter runs 0..BLOCK_W*BLOCK_H-1. The beat at the last count moves to EMIT.
  - EMIT: one cycle, InReady=0.
    - SADOut = final sum, including the last beat.
    - Row and column outputs are loaded; SADValid=1.
    - The accumulator and pixel counter clear.
    - Column increments. On wrap from SEARCH_COLS-1, column goes to 0 and row increments.
    - If the candidate was (SEARCH_ROWS-1, SEARCH_COLS-1), go to DONE; otherwise go to ACCUM.
  - DONE: one cycle, Done=1, then IDLE.
- SADOut, SADRowOut and SADColumnOut are registered. Row and column hold their last emitted values while SADValid=0; SADOut reverts to all-ones.
- Start outside IDLE is ignored. InValid outside ACCUM is ignored; no beat transfers.
- Rst has priority over every other event, including mid-block: the partial sum is discarded and no SADValid is issued.

## Timing
- SADValid is asserted the cycle after the last beat of a block is accepted.
- Candidate throughput: BLOCK_W*BLOCK_H beats plus 1 EMIT cycle.
- Done is asserted the cycle after the final SADValid.
- ACCUM is entered the cycle after Start is sampled high in IDLE.
- InValid gaps stall accumulation without loss; a gap adds only latency.

## Configuration
- SAD_EARLY_TERM_EN defined:
  - The BestSADIn port exists.
  - In ACCUM, once the running sum, including the current beat, is ≥ BestSADIn, the candidate is marked rejected.
  - Remaining beats of that block are still consumed, so stream alignment is kept.
  - In EMIT, SADValid stays 0 and SADOut stays all-ones. Row and column still advance.
  - The rejected flag clears at EMIT.
- SAD_EARLY_TERM_EN undefined:
  - BestSADIn is absent.
  - Every candidate emits SADValid.

## Test plan
- Single candidate (BLOCK 2x2, SEARCH 1x1): F={10,20,30,40}, T={12,15,30,50} -> SADOut=17, row 0, col 0, SADValid one cycle after the 4th beat; Done the next cycle.
- Raster order (BLOCK 2x2, SEARCH 2x3): 24 beats -> six SADValid pulses with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), spaced 5 cycles apart; Done once.
- Backpressure and gaps: InValid toggled 1,0,0,1,... -> same sums as a gap-free run. InReady=0 in EMIT; a pair presented during EMIT is not consumed.
- Width extremes (PIX_W=8, BLOCK 4x4): F=255, T=0 for all beats -> SADOut=4080. Swap F and T -> 4080. F=T -> 0.
- Reset mid-block: assert Rst after 2 of 4 beats -> all outputs at reset values the next cycle, no SADValid. A new Start with F={1,1,1,1}, T=0 -> SADOut=4.
- Early termination (macro defined, BLOCK 2x2): BestSADIn=10, diffs 6,6,0,0 -> no SADValid for that candidate, column advances. Next candidate with diffs 1,1,1,1 -> SADOut=4, SADValid asserted.
